// File: rtl/cordic_phase_sequencer_pkg.sv
// Shared constants and FSM encoding for the CORDIC phase sequencer.
package cordic_phase_sequencer_pkg;

  localparam int BITWIDTH = 10;
  localparam int N_FRAC = -9;
  localparam logic [BITWIDTH-1:0] PI_HALF = 10'h100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_phase_sequencer_sample_tick_gen.sv
// Sample-period counter: pulses tick once every max(prescale,1) cycles while run is high.
module cordic_phase_sequencer_sample_tick_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] period_req;
  logic             wrap;

  assign period_req = (prescale == '0) ? WIDTH'(1) : prescale;
  assign wrap       = (count == period - WIDTH'(1));
  assign tick       = run && !clear && wrap;

  // The period is only re-sampled while stopped or at a wrap, so a prescale
  // change never truncates or stretches the sample in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      period <= WIDTH'(1);
    end else if (clear || !run) begin
      count  <= '0;
      period <= period_req;
    end else if (wrap) begin
      count  <= '0;
      period <= period_req;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cordic_phase_sequencer.sv
// DDS phase accumulator feeding one amplitude/angle sample per tick to the CORDIC rotator.
// Define CORDIC_PHASE_ROUND_EN to round the angle to nearest instead of truncating.
module cordic_phase_sequencer #(
  parameter int PHASE_WIDTH    = 16,
  parameter int BITWIDTH       = cordic_phase_sequencer_pkg::BITWIDTH,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [PHASE_WIDTH-1:0]    freq_word_i,
  input  logic [BITWIDTH-1:0]       amplitude_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      cordic_done_i,
  input  logic                      overrun_clr_i,
  output logic                      strb_data_valid_o,
  output logic [BITWIDTH-1:0]       X_o,
  output logic [BITWIDTH-1:0]       Z_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  import cordic_phase_sequencer_pkg::*;

  state_t                 state;
  state_t                 state_next;
  logic [PHASE_WIDTH-1:0] phase_acc;
  logic [BITWIDTH-1:0]    angle;
  logic                   tick;
  logic                   issue;
  logic                   advance;
  logic                   drop;

  cordic_phase_sequencer_sample_tick_gen #(
    .WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .clk      (clk_i),
    .rst      (rst_i),
    .run      (state != IDLE),
    .clear    (!enable_i),
    .prescale (prescale_i),
    .tick     (tick)
  );

`ifdef CORDIC_PHASE_ROUND_EN
  // Half an output LSB added before the cut; +pi deliberately wraps to -pi.
  localparam logic [PHASE_WIDTH-1:0] HALF_LSB = PHASE_WIDTH'(1) << (PHASE_WIDTH - BITWIDTH - 1);
  logic [PHASE_WIDTH-1:0] phase_rounded;
  assign phase_rounded = phase_acc + HALF_LSB;
  assign angle         = phase_rounded[PHASE_WIDTH-1 -: BITWIDTH];
`else
  assign angle = phase_acc[PHASE_WIDTH-1 -: BITWIDTH];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // A tick coinciding with done in BUSY is served as if already READY.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    advance    = 1'b0;
    drop       = 1'b0;
    if (!enable_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = READY;
        READY: begin
          if (tick) begin
            issue      = 1'b1;
            advance    = 1'b1;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (tick) begin
            advance = 1'b1;
            if (cordic_done_i) issue = 1'b1;
            else               drop  = 1'b1;
          end else if (cordic_done_i) begin
            state_next = READY;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_acc         <= '0;
      strb_data_valid_o <= 1'b0;
      X_o               <= '0;
      Z_o               <= '0;
      overrun_o         <= 1'b0;
    end else begin
      strb_data_valid_o <= issue;
      if (!enable_i)    phase_acc <= '0;
      else if (advance) phase_acc <= phase_acc + freq_word_i;
      if (issue) begin
        X_o <= amplitude_i;
        Z_o <= angle;
      end
      if (drop)               overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
    end
  end

  assign busy_o = (state == BUSY);

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Self-checking bench for cordic_phase_sequencer: vector table, corner sequences and random run against a reference model.
module tb_cordic_phase_sequencer;
  import cordic_phase_sequencer_pkg::*;

  localparam int FS = 1 << (-N_FRAC);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] fw = '0;
  logic [9:0]  amp = '0;
  logic [15:0] pre = '0;
  logic        done = 1'b0;
  logic        clr = 1'b0;
  logic        strb;
  logic [9:0]  x;
  logic [9:0]  z;
  logic        busy;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  cordic_phase_sequencer dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (en),
    .freq_word_i       (fw),
    .amplitude_i       (amp),
    .prescale_i        (pre),
    .cordic_done_i     (done),
    .overrun_clr_i     (clr),
    .strb_data_valid_o (strb),
    .X_o               (x),
    .Z_o               (z),
    .busy_o            (busy),
    .overrun_o         (ovr)
  );

  always #5 clk = ~clk;

  // Reference model: edges counted since enable, a sample is due every P-th edge.
  bit       m_run = 0;
  bit       m_wait = 0;
  bit       m_strb = 0;
  bit       m_ovr = 0;
  int       m_t = 0;
  int       m_p = 1;
  int       m_phase = 0;
  logic [9:0] m_x = '0;
  logic [9:0] m_z = '0;

  function automatic logic [9:0] ref_angle(input int ph);
`ifdef CORDIC_PHASE_ROUND_EN
    return 10'(((ph + 32) % 65536) / 64);
`else
    return 10'(ph / 64);
`endif
  endfunction

  task automatic model_edge();
    bit dropped;
    dropped = 0;
    m_strb = 0;
    if (rst) begin
      m_run = 0; m_wait = 0; m_phase = 0; m_x = '0; m_z = '0; m_ovr = 0;
      return;
    end
    if (!en) begin
      m_run = 0; m_wait = 0; m_phase = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0; m_p = (pre == 0) ? 1 : int'(pre);
    end else begin
      m_t++;
      if (m_t % m_p == 0) begin
        if (!m_wait || done) begin
          m_strb = 1; m_z = ref_angle(m_phase); m_x = amp; m_wait = 1;
        end else begin
          dropped = 1;
        end
        m_phase = (m_phase + int'(fw)) % 65536;
      end else if (done) begin
        m_wait = 0;
      end
    end
    if (dropped) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", 64'({strb, busy, ovr, x, z}), 64'({m_strb, m_wait, m_ovr, m_x, m_z}));
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (strb) ok = 1;
    end
  endtask

  typedef struct {
    logic [15:0]      fw;
    logic [15:0]      pre;
    logic [9:0]       amp;
    int               dly;
    int               period;
    logic [4:0][9:0]  z;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] f, input logic [15:0] p, input logic [9:0] a,
                              input int d, input int per, input logic [9:0] z0, input logic [9:0] z1,
                              input logic [9:0] z2, input logic [9:0] z3, input logic [9:0] z4);
    vec_t v;
    v.fw = f; v.pre = p; v.amp = a; v.dly = d; v.period = per;
    v.z = {z4, z3, z2, z1, z0};
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    bit ok;
    int n;
    int last;
    int pend;

    vecs[0] = mk(16'h0400, 16'd20, 10'h0FF, 11, 20, 10'h000, 10'h010, 10'h020, 10'h030, 10'h040);
    vecs[1] = mk(16'h4000, 16'd16, 10'h155, 3, 16, 10'h000, PI_HALF, 10'(FS), 10'(3 * PI_HALF), 10'h000);
    vecs[2] = mk(16'h1000, 16'd11, 10'h200, 10, 11, 10'h000, 10'h040, 10'h080, 10'h0C0, 10'h100);
    vecs[3] = mk(16'h0040, 16'd0, 10'h3FF, 0, 1, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004);
`ifdef CORDIC_PHASE_ROUND_EN
    vecs[4] = mk(16'h0020, 16'd2, 10'h011, 0, 2, 10'h000, 10'h001, 10'h001, 10'h002, 10'h002);
    vecs[5] = mk(16'h7FE0, 16'd2, 10'h1F0, 0, 2, 10'h000, 10'(FS), 10'h3FF, 10'h1FF, 10'h3FE);
`else
    vecs[4] = mk(16'h0020, 16'd2, 10'h011, 0, 2, 10'h000, 10'h000, 10'h001, 10'h001, 10'h002);
    vecs[5] = mk(16'h7FE0, 16'd2, 10'h1F0, 0, 2, 10'h000, 10'h1FF, 10'h3FF, 10'h1FE, 10'h3FE);
`endif

    rst = 1; amp = 10'h2AA; fw = 16'h1234;
    step(); step(); step();
    chk("reset_state", 64'({strb, busy, ovr, x, z}), 64'(0));
    rst = 0;

    foreach (vecs[v]) begin
      en = 0; done = 0; clr = 0;
      step(); step();
      fw = vecs[v].fw; pre = vecs[v].pre; amp = vecs[v].amp; en = 1;
      n = 0; last = 0; pend = -1;
      for (int c = 0; c < vecs[v].period * 6 + 40 && n < 5; c++) begin
        done = (c == pend);
        step();
        if (strb) begin
          chk($sformatf("vec%0d_z%0d", v, n), 64'(z), 64'(vecs[v].z[n]));
          chk($sformatf("vec%0d_x%0d", v, n), 64'(x), 64'(vecs[v].amp));
          chk($sformatf("vec%0d_ovr%0d", v, n), 64'(ovr), 64'(0));
          if (n > 0) chk($sformatf("vec%0d_period%0d", v, n), 64'(c - last), 64'(vecs[v].period));
          last = c; n++; pend = c + 1 + vecs[v].dly;
        end
      end
      done = 0;
      chk($sformatf("vec%0d_strobe_count", v), 64'(n), 64'(5));
    end

    // Overrun: two ticks land while busy and are dropped, the phase keeps moving.
    en = 0; step(); step();
    pre = 16'd5; fw = 16'h0100; amp = 10'h123; en = 1;
    wait_strobe(40, ok);
    chk("ovr_first_strobe", 64'(ok), 64'(1));
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      done = (k == 12); clr = (k == 16);
      step();
      if (k == 11) chk("ovr_set", 64'(ovr), 64'(1));
      if (k < 15 && strb) n++;
      if (k == 15) begin
        chk("ovr_strobe_at_15", 64'(strb), 64'(1));
        chk("ovr_z", 64'(z), 64'(10'h00C));
      end
    end
    chk("ovr_no_strobe_while_busy", 64'(n), 64'(0));
    chk("ovr_cleared", 64'(ovr), 64'(0));
    done = 0; clr = 0;

    // Disable mid-BUSY, then a stray done must not restart anything.
    en = 0; step(); step();
    pre = 16'd20; fw = 16'h0400; en = 1;
    wait_strobe(40, ok);
    chk("dis_first_strobe", 64'(ok), 64'(1));
    step(); step(); step();
    en = 0; step();
    done = 1; step(); done = 0;
    n = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (strb || busy) n++;
    end
    chk("dis_stays_idle", 64'(n), 64'(0));
    en = 1;
    wait_strobe(40, ok);
    chk("reen_strobe", 64'(ok), 64'(1));
    chk("reen_z_zero", 64'(z), 64'(0));

    // Reset while BUSY.
    step(); step();
    rst = 1; step();
    chk("rst_mid_busy", 64'({strb, busy, ovr, x, z}), 64'(0));
    rst = 0;

    // Random traffic checked cycle by cycle against the model.
    pend = -1;
    for (int c = 0; c < 4000; c++) begin
      done = (c == pend) || ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 29) == 0);
      amp = 10'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) fw = 16'($urandom);
      if (!en) begin
        if ($urandom_range(0, 2) == 0) en = 1;
      end else if ($urandom_range(0, 99) == 0) begin
        en = 0;
        pre = 16'($urandom_range(0, 12));
      end
      step();
      if (strb) pend = c + 1 + $urandom_range(0, 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
